// File: rtl/axi_datamover_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_datamover_pkg
//  Purpose  : Shared definitions for the multi-channel DataMover read front-end:
//             MM2S command field layout, status bit positions, response codes,
//             read FSM state encoding and the order-FIFO entry format.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_datamover_pkg;

    // MM2S command word layout. The address field width is a module parameter,
    // so the tag/reserved offsets are computed from SADDR_LSB by the user.
    localparam int c_CMD_BTT_LSB   = 0;
    localparam int c_CMD_BTT_W     = 23;
    localparam int c_CMD_TYPE_BIT  = 23;
    localparam int c_CMD_DSA_LSB   = 24;
    localparam int c_CMD_DSA_W     = 6;
    localparam int c_CMD_EOF_BIT   = 30;
    localparam int c_CMD_DRR_BIT   = 31;
    localparam int c_CMD_SADDR_LSB = 32;
    localparam int c_CMD_TAG_W     = 4;
    localparam int c_CMD_RSV_W     = 4;

    // MM2S status byte layout; the low nibble echoes the command tag.
    localparam int c_STS_OKAY_BIT   = 7;
    localparam int c_STS_SLVERR_BIT = 6;
    localparam int c_STS_DECERR_BIT = 5;
    localparam int c_STS_INTERR_BIT = 4;
    localparam int c_STS_TAG_W      = 4;

    typedef logic [1:0] resp_t;
    localparam resp_t c_RESP_OKAY   = 2'd0;
    localparam resp_t c_RESP_SLVERR = 2'd2;
    localparam resp_t c_RESP_DECERR = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rd_state_t;

    // One entry per issued command: owning channel and "last chunk of request".
    typedef struct packed {
        logic       last_chunk;
        logic [2:0] ch;
    } order_t;

    // DECERR dominates; SLVERR and internal errors both map to SLVERR.
    function automatic resp_t sts_code(input logic [7:0] sts);
        if (sts[c_STS_DECERR_BIT]) begin
            return c_RESP_DECERR;
        end else if (sts[c_STS_SLVERR_BIT] || sts[c_STS_INTERR_BIT]) begin
            return c_RESP_SLVERR;
        end else begin
            return c_RESP_OKAY;
        end
    endfunction

    function automatic resp_t resp_max(input resp_t a, input resp_t b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with combinational head read. Simultaneous
//             push and pop both take effect (count unchanged).
//  Ports    : clk, rst (sync, active-high)
//             push/push_data  - write side (ignored when full)
//             pop/pop_data    - read side  (ignored when empty), head visible
//             full, empty, almost_full (one free slot left)
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign w_push_ok   = push & ~full;
    assign w_pop_ok    = pop & ~empty;
    assign full        = (r_count == c_CW'(DEPTH));
    assign empty       = (r_count == '0);
    assign almost_full = (r_count == c_CW'(DEPTH - 1));
    assign pop_data    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= (r_wptr == c_AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= (r_rptr == c_AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_datamover_read_mc.sv
`default_nettype none
// ============================================================================
//  Module   : axi_datamover_read_mc
//  Purpose  : Multi-channel read front-end for an AXI DataMover (MM2S).
//             Round-robin accepts per-channel read requests, splits each into
//             CHUNK_BYTES commands, routes returned beats to the owning
//             channel in command order and folds status into one response
//             per request.
//  Ports    : clk, rst (sync, active-high)
//             ddr_rreq_*    - per-channel request handshake, addr, size
//             ddr_rdata_*   - shared read-data stream with owning channel
//             ddr_rresp_*   - one response pulse per completed request
//             err_zero_size - sticky: a zero-length request was discarded
//             mm2s_cmd_*, mm2s_*, mm2s_sts_* - DataMover MM2S interfaces
//  Revision : 1.0 - initial release
// ============================================================================
module axi_datamover_read_mc
    import axi_datamover_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int SIZE_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_BYTES = 4096,
    parameter int OUTSTANDING = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ddr_rreq_valid,
    output logic [NUM_CH-1:0]              ddr_rreq_ready,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ddr_rreq_addr,
    input  logic [NUM_CH*SIZE_WIDTH-1:0]   ddr_rreq_size,
    output logic                           ddr_rdata_valid,
    input  logic                           ddr_rdata_ready,
    output logic                           ddr_rdata_last,
    output logic [DATA_WIDTH-1:0]          ddr_rdata,
    output logic [2:0]                     ddr_rdata_ch,
    output logic                           ddr_rresp_valid,
    output logic [1:0]                     ddr_rresp,
    output logic [2:0]                     ddr_rresp_ch,
    output logic                           err_zero_size,
    output logic [ADDR_WIDTH+39:0]         mm2s_cmd_tdata,
    output logic                           mm2s_cmd_tvalid,
    input  logic                           mm2s_cmd_tready,
    input  logic [DATA_WIDTH-1:0]          mm2s_tdata,
    input  logic [DATA_WIDTH/8-1:0]        mm2s_tkeep,
    input  logic                           mm2s_tlast,
    input  logic                           mm2s_tvalid,
    output logic                           mm2s_tready,
    input  logic [7:0]                     mm2s_sts_tdata,
    input  logic [0:0]                     mm2s_sts_tkeep,
    input  logic                           mm2s_sts_tlast,
    input  logic                           mm2s_sts_tvalid,
    output logic                           mm2s_sts_tready
);

    localparam int c_CH_W  = 3;
    localparam int c_SUM_W = c_CH_W + 1;
    localparam int c_TAG_LSB = c_CMD_SADDR_LSB + ADDR_WIDTH;
    localparam int c_CMD_W = c_TAG_LSB + c_CMD_TAG_W + c_CMD_RSV_W;
    localparam logic [SIZE_WIDTH-1:0] c_CHUNK = SIZE_WIDTH'(CHUNK_BYTES);

    rd_state_t               r_state, w_state_next;
    logic [c_CH_W-1:0]       r_rr_ptr;
    logic [c_CH_W-1:0]       r_ch;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [SIZE_WIDTH-1:0]   r_remaining;
    logic [c_CMD_W-1:0]      r_cmd_tdata;
    logic                    r_cmd_tvalid;
    resp_t                   r_err [NUM_CH];
    logic                    r_rresp_valid;
    resp_t                   r_rresp;
    logic [c_CH_W-1:0]       r_rresp_ch;
    logic                    r_err_zero;

    logic [2*NUM_CH-1:0]     w_rr_rot;
    logic                    w_gnt_found;
    logic [c_CH_W-1:0]       w_gnt_ch;
    logic                    w_grant_en;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [SIZE_WIDTH-1:0]   w_sel_size;
    logic                    w_req_zero;
    logic                    w_cmd_fire;
    logic [SIZE_WIDTH-1:0]   w_btt;
    logic                    w_last_chunk;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic [SIZE_WIDTH-1:0]   w_rem_next;
    logic                    w_fifo_full, w_fifo_empty, w_fifo_afull;
    logic                    w_fifo_pop;
    logic                    w_full_next;
    logic                    w_mm2s_tready;
    order_t                  w_push_entry, w_head;
    logic                    w_sts_accept;
    resp_t                   w_sts_code;
    logic [c_CH_W-1:0]       w_sts_ch;
    resp_t                   w_err_sel;
    logic                    w_unused_ok;

    function automatic logic [c_CH_W-1:0] rr_wrap(input logic [c_CH_W-1:0] ptr,
                                                  input int unsigned off);
        logic [c_SUM_W-1:0] s;
        s = {1'b0, ptr} + c_SUM_W'(off);
        if (s >= c_SUM_W'(NUM_CH)) begin
            s = s - c_SUM_W'(NUM_CH);
        end
        return s[c_CH_W-1:0];
    endfunction

    function automatic logic [c_CMD_W-1:0] build_cmd(input logic [c_CH_W-1:0]     ch,
                                                     input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic [SIZE_WIDTH-1:0] rem);
        logic [SIZE_WIDTH-1:0] btt;
        logic                  fin;
        logic [c_CMD_W-1:0]    cmd;
        fin = (rem <= c_CHUNK);
        btt = fin ? rem : c_CHUNK;
        cmd = '0;
        cmd[c_CMD_BTT_LSB +: c_CMD_BTT_W]   = c_CMD_BTT_W'(btt);
        cmd[c_CMD_TYPE_BIT]                 = 1'b1;
        cmd[c_CMD_DSA_LSB +: c_CMD_DSA_W]   = '0;
        cmd[c_CMD_EOF_BIT]                  = 1'b1;
        cmd[c_CMD_DRR_BIT]                  = 1'b0;
        cmd[c_CMD_SADDR_LSB +: ADDR_WIDTH]  = addr;
        cmd[c_TAG_LSB +: c_CMD_TAG_W]       = {fin, ch};
        cmd[c_TAG_LSB + c_CMD_TAG_W +: c_CMD_RSV_W] = '0;
        return cmd;
    endfunction

    // ---------------- Arbiter ----------------
    // Rotating the doubled valid vector by the last grant puts the channel
    // one above it at bit 1, so the search order is a plain ascending scan.
    assign w_rr_rot = {ddr_rreq_valid, ddr_rreq_valid} >> r_rr_ptr;

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_ch    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!w_gnt_found && w_rr_rot[i]) begin
                w_gnt_found = 1'b1;
                w_gnt_ch    = rr_wrap(r_rr_ptr, i);
            end
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_size = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_gnt_ch == c_CH_W'(c)) begin
                w_sel_addr = ddr_rreq_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_size = ddr_rreq_size[c*SIZE_WIDTH +: SIZE_WIDTH];
            end
        end
    end

    assign w_grant_en = (r_state == ST_IDLE) && !w_fifo_full && w_gnt_found;
    assign w_req_zero = (w_sel_size == '0);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_rreq_ready
        assign ddr_rreq_ready[c] = w_grant_en && (w_gnt_ch == c_CH_W'(c));
    end

    // ---------------- Command issue ----------------
    assign w_cmd_fire   = r_cmd_tvalid & mm2s_cmd_tready;
    assign w_last_chunk = (r_remaining <= c_CHUNK);
    assign w_btt        = w_last_chunk ? r_remaining : c_CHUNK;
    assign w_addr_next  = r_addr + ADDR_WIDTH'(w_btt);
    assign w_rem_next   = r_remaining - w_btt;

    // tvalid is registered, so it must look at FIFO occupancy after this
    // cycle's push/pop to avoid presenting a command the FIFO cannot record.
    always_comb begin
        if (w_cmd_fire && !w_fifo_pop) begin
            w_full_next = w_fifo_full | w_fifo_afull;
        end else if (!w_cmd_fire && w_fifo_pop) begin
            w_full_next = 1'b0;
        end else begin
            w_full_next = w_fifo_full;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_en && !w_req_zero) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_cmd_fire && w_last_chunk) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_ch         <= '0;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_cmd_tdata  <= '0;
            r_cmd_tvalid <= 1'b0;
            r_err_zero   <= 1'b0;
        end else if (w_grant_en) begin
            r_rr_ptr <= w_gnt_ch;
            if (w_req_zero) begin
                r_err_zero <= 1'b1;
            end else begin
                r_ch         <= w_gnt_ch;
                r_addr       <= w_sel_addr;
                r_remaining  <= w_sel_size;
                r_cmd_tdata  <= build_cmd(w_gnt_ch, w_sel_addr, w_sel_size);
                r_cmd_tvalid <= 1'b1;
            end
        end else if (r_state == ST_ISSUE) begin
            if (w_cmd_fire) begin
                r_addr      <= w_addr_next;
                r_remaining <= w_rem_next;
                if (w_last_chunk) begin
                    r_cmd_tvalid <= 1'b0;
                end else begin
                    r_cmd_tdata  <= build_cmd(r_ch, w_addr_next, w_rem_next);
                    r_cmd_tvalid <= !w_full_next;
                end
            end else begin
                r_cmd_tvalid <= !w_full_next;
            end
        end
    end

    assign mm2s_cmd_tdata  = r_cmd_tdata;
    assign mm2s_cmd_tvalid = r_cmd_tvalid;
    assign err_zero_size   = r_err_zero;

    // ---------------- Order FIFO and data path ----------------
    assign w_push_entry = '{last_chunk: w_last_chunk, ch: r_ch};

    sync_fifo #(
        .WIDTH (4),
        .DEPTH (OUTSTANDING)
    ) u_order_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (w_cmd_fire),
        .push_data   (w_push_entry),
        .pop         (w_fifo_pop),
        .pop_data    (w_head),
        .full        (w_fifo_full),
        .empty       (w_fifo_empty),
        .almost_full (w_fifo_afull)
    );

    assign w_mm2s_tready   = ddr_rdata_ready & ~w_fifo_empty;
    assign w_fifo_pop      = mm2s_tvalid & w_mm2s_tready & mm2s_tlast;
    assign mm2s_tready     = w_mm2s_tready;
    assign ddr_rdata_valid = mm2s_tvalid & ~w_fifo_empty;
    assign ddr_rdata       = mm2s_tdata;
    assign ddr_rdata_ch    = w_head.ch;
    assign ddr_rdata_last  = mm2s_tlast & w_head.last_chunk;

    // ---------------- Status / response ----------------
    assign mm2s_sts_tready = 1'b1;
    assign w_sts_accept    = mm2s_sts_tvalid & mm2s_sts_tkeep[0];
    assign w_sts_code      = sts_code(mm2s_sts_tdata);
    assign w_sts_ch        = mm2s_sts_tdata[c_CH_W-1:0];

    always_comb begin
        w_err_sel = c_RESP_OKAY;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sts_ch == c_CH_W'(c)) begin
                w_err_sel = r_err[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rresp_valid <= 1'b0;
            r_rresp       <= c_RESP_OKAY;
            r_rresp_ch    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_err[c] <= c_RESP_OKAY;
            end
        end else begin
            r_rresp_valid <= w_sts_accept & mm2s_sts_tdata[c_STS_TAG_W-1];
            if (w_sts_accept && mm2s_sts_tdata[c_STS_TAG_W-1]) begin
                r_rresp    <= resp_max(w_err_sel, w_sts_code);
                r_rresp_ch <= w_sts_ch;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_sts_accept && (w_sts_ch == c_CH_W'(c))) begin
                    r_err[c] <= mm2s_sts_tdata[c_STS_TAG_W-1] ? c_RESP_OKAY
                                                              : resp_max(r_err[c], w_sts_code);
                end
            end
        end
    end

    assign ddr_rresp_valid = r_rresp_valid;
    assign ddr_rresp       = r_rresp;
    assign ddr_rresp_ch    = r_rresp_ch;

    // Byte enables and status tlast carry nothing this block acts on.
    assign w_unused_ok = ^{mm2s_tkeep, mm2s_sts_tlast, mm2s_sts_tdata[c_STS_OKAY_BIT]};

endmodule
`default_nettype wire

// File: tb/tb_axi_datamover_read_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_datamover_read_mc
//  Purpose  : Self-checking bench for axi_datamover_read_mc (4 channels,
//             order FIFO depth 2, 4 KiB chunks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_datamover_read_mc;

    localparam int c_NCH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         rq_valid = '0;
    logic [3:0]         rq_ready;
    logic [127:0]       rq_addr = '0;
    logic [127:0]       rq_size = '0;
    logic               rd_valid, rd_last;
    logic               rd_ready = 1'b0;
    logic [63:0]        rd_data;
    logic [2:0]         rd_ch;
    logic               rs_valid;
    logic [1:0]         rs_resp;
    logic [2:0]         rs_ch;
    logic               err_zero;
    logic [71:0]        cmd_tdata;
    logic               cmd_tvalid;
    logic               cmd_tready = 1'b0;
    logic [63:0]        m_tdata = '0;
    logic [7:0]         m_tkeep = 8'hFF;
    logic               m_tlast = 1'b0;
    logic               m_tvalid = 1'b0;
    logic               m_tready;
    logic [7:0]         s_tdata = '0;
    logic [0:0]         s_tkeep = 1'b0;
    logic               s_tlast = 1'b1;
    logic               s_tvalid = 1'b0;
    logic               s_tready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    axi_datamover_read_mc #(
        .NUM_CH      (c_NCH),
        .ADDR_WIDTH  (32),
        .SIZE_WIDTH  (32),
        .DATA_WIDTH  (64),
        .CHUNK_BYTES (4096),
        .OUTSTANDING (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ddr_rreq_valid  (rq_valid),
        .ddr_rreq_ready  (rq_ready),
        .ddr_rreq_addr   (rq_addr),
        .ddr_rreq_size   (rq_size),
        .ddr_rdata_valid (rd_valid),
        .ddr_rdata_ready (rd_ready),
        .ddr_rdata_last  (rd_last),
        .ddr_rdata       (rd_data),
        .ddr_rdata_ch    (rd_ch),
        .ddr_rresp_valid (rs_valid),
        .ddr_rresp       (rs_resp),
        .ddr_rresp_ch    (rs_ch),
        .err_zero_size   (err_zero),
        .mm2s_cmd_tdata  (cmd_tdata),
        .mm2s_cmd_tvalid (cmd_tvalid),
        .mm2s_cmd_tready (cmd_tready),
        .mm2s_tdata      (m_tdata),
        .mm2s_tkeep      (m_tkeep),
        .mm2s_tlast      (m_tlast),
        .mm2s_tvalid     (m_tvalid),
        .mm2s_tready     (m_tready),
        .mm2s_sts_tdata  (s_tdata),
        .mm2s_sts_tkeep  (s_tkeep),
        .mm2s_sts_tlast  (s_tlast),
        .mm2s_sts_tvalid (s_tvalid),
        .mm2s_sts_tready (s_tready)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {rsv, tag, saddr, drr, eof, dsa, type, btt}
    function automatic logic [71:0] mkcmd(input logic [3:0] tag, input logic [31:0] addr,
                                          input logic [22:0] btt);
        return {4'h0, tag, addr, 1'b0, 1'b1, 6'h00, 1'b1, btt};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic [31:0] addr, input logic [31:0] size);
        rq_addr[ch*32 +: 32] = addr;
        rq_size[ch*32 +: 32] = size;
    endtask

    // One data beat presented at a negedge; consumed at the following posedge.
    task automatic beat(input string name, input logic [63:0] d, input logic last,
                        input logic exp_last, input logic [2:0] exp_ch);
        @(negedge clk);
        m_tvalid = 1'b1;
        m_tdata  = d;
        m_tlast  = last;
        rd_ready = 1'b1;
        #1;
        chk({name, "_valid"}, rd_valid, 1'b1);
        chk({name, "_tready"}, m_tready, 1'b1);
        chk({name, "_ch"}, rd_ch, exp_ch);
        chk({name, "_last"}, rd_last, exp_last);
        chk({name, "_data"}, rd_data, d);
    endtask

    typedef struct {
        logic [7:0] sts;
        logic       keep;
        logic       exp_valid;
        logic [1:0] exp_resp;
        logic [2:0] exp_ch;
    } sts_vec_t;

    sts_vec_t vecs [14];

    initial begin
        vecs[0]  = '{8'h88, 1'b1, 1'b1, 2'd0, 3'd0};
        vecs[1]  = '{8'h81, 1'b1, 1'b0, 2'd0, 3'd0};
        vecs[2]  = '{8'hC1, 1'b1, 1'b0, 2'd0, 3'd0};
        vecs[3]  = '{8'h89, 1'b1, 1'b1, 2'd2, 3'd1};
        vecs[4]  = '{8'h2A, 1'b1, 1'b1, 2'd3, 3'd2};
        vecs[5]  = '{8'h1B, 1'b1, 1'b1, 2'd2, 3'd3};
        vecs[6]  = '{8'h62, 1'b1, 1'b0, 2'd0, 3'd0};
        vecs[7]  = '{8'h8A, 1'b1, 1'b1, 2'd3, 3'd2};
        vecs[8]  = '{8'h8A, 1'b1, 1'b1, 2'd0, 3'd2};
        vecs[9]  = '{8'h2B, 1'b0, 1'b0, 2'd0, 3'd0};
        vecs[10] = '{8'h8B, 1'b1, 1'b1, 2'd0, 3'd3};
        vecs[11] = '{8'h31, 1'b1, 1'b0, 2'd0, 3'd0};
        vecs[12] = '{8'h51, 1'b1, 1'b0, 2'd0, 3'd0};
        vecs[13] = '{8'h89, 1'b1, 1'b1, 2'd3, 3'd1};

        // ---------------- Reset state ----------------
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_tvalid = 1'b1;
        rd_ready = 1'b1;
        #1;
        chk("rst_cmd_tvalid", cmd_tvalid, 1'b0);
        chk("rst_cmd_tdata", cmd_tdata, 72'h0);
        chk("rst_rresp_valid", rs_valid, 1'b0);
        chk("rst_rresp", rs_resp, 2'd0);
        chk("rst_rresp_ch", rs_ch, 3'd0);
        chk("rst_err_zero", err_zero, 1'b0);
        chk("rst_rreq_ready", rq_ready, 4'b0000);
        chk("rst_rdata_valid", rd_valid, 1'b0);
        chk("rst_mm2s_tready", m_tready, 1'b0);
        chk("rst_sts_tready", s_tready, 1'b1);
        m_tvalid = 1'b0;
        rd_ready = 1'b0;

        // ---------------- ch1, 10000 bytes from 0x1000, FIFO depth 2 --------
        @(negedge clk);
        set_req(1, 32'h1000, 32'd10000);
        rq_valid = 4'b0010;
        #1;
        chk("split_ready", rq_ready, 4'b0010);
        @(negedge clk);
        rq_valid = 4'b0000;
        chk("split_c1_valid", cmd_tvalid, 1'b1);
        chk("split_c1_data", cmd_tdata, mkcmd(4'h1, 32'h1000, 23'd4096));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_tvalid", cmd_tvalid, 1'b1);
            chk("stall_tdata", cmd_tdata, mkcmd(4'h1, 32'h1000, 23'd4096));
            m_tvalid = 1'b1;
            rd_ready = 1'b1;
            #1;
            chk("stall_no_push", rd_valid, 1'b0);
        end
        @(negedge clk);
        m_tvalid   = 1'b0;
        cmd_tready = 1'b1;
        @(negedge clk);
        chk("split_c2_valid", cmd_tvalid, 1'b1);
        chk("split_c2_data", cmd_tdata, mkcmd(4'h1, 32'h2000, 23'd4096));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_c3_held", cmd_tvalid, 1'b0);
            chk("full_c3_data", cmd_tdata, mkcmd(4'h9, 32'h3000, 23'd1808));
        end
        @(negedge clk);
        m_tvalid = 1'b1;
        m_tlast  = 1'b0;
        rd_ready = 1'b0;
        #1;
        chk("bp_rdata_valid", rd_valid, 1'b1);
        chk("bp_mm2s_tready", m_tready, 1'b0);
        beat("c1b0", 64'h1111_0000_0000_0001, 1'b0, 1'b0, 3'd1);
        beat("c1b1", 64'h1111_0000_0000_0002, 1'b1, 1'b0, 3'd1);
        @(negedge clk);
        m_tvalid = 1'b0;
        chk("c3_valid", cmd_tvalid, 1'b1);
        chk("c3_data", cmd_tdata, mkcmd(4'h9, 32'h3000, 23'd1808));
        @(negedge clk);
        chk("split_done", cmd_tvalid, 1'b0);
        beat("c2b0", 64'h2222_0000_0000_0001, 1'b0, 1'b0, 3'd1);
        beat("c2b1", 64'h2222_0000_0000_0002, 1'b1, 1'b0, 3'd1);
        beat("c3b0", 64'h3333_0000_0000_0001, 1'b0, 1'b0, 3'd1);
        beat("c3b1", 64'h3333_0000_0000_0002, 1'b1, 1'b1, 3'd1);
        @(negedge clk);
        m_tlast = 1'b0;
        #1;
        chk("drained_valid", rd_valid, 1'b0);
        m_tvalid = 1'b0;

        // ---------------- Round robin from pointer 0 ----------------
        do_reset();
        @(negedge clk);
        set_req(0, 32'h100, 32'd8);
        set_req(2, 32'h200, 32'd16);
        rq_valid = 4'b0101;
        #1;
        chk("rr_first", rq_ready, 4'b0100);
        @(negedge clk);
        chk("rr_busy", rq_ready, 4'b0000);
        chk("rr_cmd_ch2", cmd_tdata, mkcmd(4'hA, 32'h200, 23'd16));
        @(negedge clk);
        chk("rr_second", rq_ready, 4'b0001);
        @(negedge clk);
        rq_valid = 4'b0000;
        chk("rr_cmd_ch0", cmd_tdata, mkcmd(4'h8, 32'h100, 23'd8));
        beat("rr_b_ch2", 64'hAAAA_0000_0000_0002, 1'b1, 1'b1, 3'd2);
        beat("rr_b_ch0", 64'hAAAA_0000_0000_0000, 1'b1, 1'b1, 3'd0);
        @(negedge clk);
        m_tvalid = 1'b0;

        // ---------------- Zero-size request on ch3 ----------------
        set_req(3, 32'h4000, 32'd0);
        rq_valid = 4'b1000;
        #1;
        chk("zero_ready", rq_ready, 4'b1000);
        @(negedge clk);
        rq_valid = 4'b0000;
        chk("zero_flag", err_zero, 1'b1);
        chk("zero_no_cmd", cmd_tvalid, 1'b0);
        @(negedge clk);
        chk("zero_no_cmd2", cmd_tvalid, 1'b0);
        chk("zero_no_resp", rs_valid, 1'b0);
        chk("zero_sticky", err_zero, 1'b1);

        // ---------------- Reset mid-ISSUE ----------------
        @(negedge clk);
        set_req(1, 32'h1000, 32'd10000);
        rq_valid = 4'b0010;
        @(negedge clk);
        rq_valid = 4'b0000;
        @(negedge clk);
        cmd_tready = 1'b0;
        chk("mid_issue_tvalid", cmd_tvalid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_tvalid", cmd_tvalid, 1'b0);
        chk("mid_rst_tdata", cmd_tdata, 72'h0);
        chk("mid_rst_err_zero", err_zero, 1'b0);
        chk("mid_rst_rresp_valid", rs_valid, 1'b0);
        m_tvalid = 1'b1;
        rd_ready = 1'b1;
        #1;
        chk("mid_rst_fifo_empty", rd_valid, 1'b0);
        m_tvalid = 1'b0;

        // ---------------- Status decode / accumulation table ----------------
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("sts_valid", rs_valid, vecs[i-1].exp_valid);
                if (vecs[i-1].exp_valid) begin
                    chk("sts_resp", rs_resp, vecs[i-1].exp_resp);
                    chk("sts_ch", rs_ch, vecs[i-1].exp_ch);
                end
            end
            if (i < 14) begin
                s_tvalid = 1'b1;
                s_tdata  = vecs[i].sts;
                s_tkeep  = vecs[i].keep;
            end else begin
                s_tvalid = 1'b0;
            end
        end
        @(negedge clk);
        chk("sts_pulse_end", rs_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_datamover_read_mc.md
AXI_DATAMOVER_READ_MC -- requirements
Module: axi_datamover_read_mc

Interface
REQ-001 Parameters: NUM_CH, default 4, read channels (1..8); ADDR_WIDTH, 32, address bits; SIZE_WIDTH, 32, request byte count; DATA_WIDTH, 64, stream bits; CHUNK_BYTES, 4096, max BTT per command (power of two, ≥ DATA_WIDTH/8); OUTSTANDING, 8, order-FIFO depth (power of two).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ddr_rreq_valid / ddr_rreq_ready  in / out  NUM_CH  per-channel request handshake.
REQ-005 ddr_rreq_addr  in  NUM_CH*ADDR_WIDTH  per-channel start byte address, channel c at slice c.
REQ-006 ddr_rreq_size  in  NUM_CH*SIZE_WIDTH  per-channel byte count.
REQ-007 ddr_rdata_valid / ddr_rdata_ready / ddr_rdata_last  out / in / out  1  shared read-data stream; last marks end of a whole request.
REQ-008 ddr_rdata / ddr_rdata_ch  out  DATA_WIDTH / 3  beat data, owning channel.
REQ-009 ddr_rresp_valid / ddr_rresp / ddr_rresp_ch  out  1 / 2 / 3  one response pulse per request.
REQ-010 err_zero_size  out  1  sticky flag: zero-size request discarded.
REQ-011 mm2s_cmd_tdata / mm2s_cmd_tvalid / mm2s_cmd_tready  out / out / in  72 / 1 / 1  DataMover command stream.
REQ-012 mm2s_tdata, mm2s_tkeep, mm2s_tlast, mm2s_tvalid in; mm2s_tready out  DataMover read stream.
REQ-013 mm2s_sts_tdata (8), mm2s_sts_tkeep (1), mm2s_sts_tlast, mm2s_sts_tvalid in; mm2s_sts_tready out  status stream.

Function
REQ-014 Arbiter: round-robin among valid channels, search starting one above last granted; grant only in IDLE with order FIFO not full.
REQ-015 ddr_rreq_ready[c] SHALL be combinational, high only for granted channel in IDLE; at most one bit high.
REQ-016 On accepted request: latch ch, addr, remaining=size; FSM IDLE->ISSUE; size 0 instead stays IDLE, sets err_zero_size, no command, no response.
REQ-017 ISSUE: btt=min(remaining,CHUNK_BYTES); mm2s_cmd_tvalid registered, held with stable tdata until tready.
REQ-018 Command word: {rsv=0, tag, saddr, drr=0, eof=1, dsa=0, type=1, btt zero-extended to 23 bits}; tag[2:0]=ch, tag[3]=1 on final chunk.
REQ-019 On command handshake: push {ch,final} to order FIFO, addr+=btt, remaining-=btt; remaining==0 -> IDLE, else stay ISSUE; order FIFO full -> tvalid deasserted until space, tdata unchanged.
REQ-020 Data path zero latency: ddr_rdata_valid = mm2s_tvalid & !fifo_empty; mm2s_tready = ddr_rdata_ready & !fifo_empty; ddr_rdata=mm2s_tdata; ddr_rdata_ch=head.ch; ddr_rdata_last = mm2s_tlast & head.final.
REQ-021 Order FIFO pops on mm2s_tvalid&mm2s_tready&mm2s_tlast; push and pop in the same cycle SHALL both take effect, count unchanged.
REQ-022 mm2s_sts_tready tied 1; status accepted when tvalid and tkeep[0]=1; tkeep[0]=0 ignored.
REQ-023 Status decode: bit7 OKAY, bit6 SLVERR, bit5 DECERR, bit4 INTERR; code DECERR=3 over SLVERR/INTERR=2 over OKAY=0.
REQ-024 Per-channel accumulator err[ch]=max(err[ch],code); on tag[3]=1, 1 cycle later pulse ddr_rresp_valid with ddr_rresp=max(err,code), ddr_rresp_ch=tag[2:0], clear err[ch].
REQ-025 Address add wraps modulo 2^ADDR_WIDTH; no 4 KiB boundary logic (DataMover handles).

Reset
REQ-026 rst: FSM IDLE, rr pointer 0, order FIFO empty, accumulators 0, mm2s_cmd_tvalid=0, mm2s_cmd_tdata=0, ddr_rresp_valid=0, ddr_rresp=0, ddr_rresp_ch=0, err_zero_size=0.
REQ-027 Reset mid-transfer SHALL abandon all outstanding commands; DataMover reset is external and concurrent.

Structure
REQ-028 Package axi_datamover_pkg: command field widths/offsets, status bit positions, resp codes OKAY/SLVERR/DECERR.
REQ-029 One sub-module sync_fifo (width 4, depth OUTSTANDING, full/empty) for the order FIFO.

Verification
REQ-030 ch1 addr 0x1000 size 10000, CHUNK 4096 -> 3 commands btt 4096/4096/1808, addr 0x1000/0x2000/0x3000, tag 0x1/0x1/0x9; ddr_rdata_last only on last beat of third.
REQ-031 ch0 and ch2 valid same cycle, rr pointer 0 -> ch2 granted first, then ch0; rdata_ch follows command order.
REQ-032 Three chunks, statuses 0x81, 0xC1, 0x89 -> single rresp_valid, rresp=2, ch=1, one cycle after third status.
REQ-033 mm2s_cmd_tready held low 5 cycles -> tdata stable, no FIFO push; OUTSTANDING=2 with no data returned -> third command stalled.
REQ-034 size 0 on ch3 -> ready pulse, err_zero_size=1, no command, no response; rst asserted mid-ISSUE -> all outputs at reset values next cycle.
